// File: rtl/mpi_credit_arbiter_if.sv
// Bundle of the requester-side and link-side signals of the MPI credit arbiter.
// The arbiter uses the slave view; whoever drives requests and observes the
// link (a requester fabric or a testbench) uses the master view.
interface mpi_credit_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int CREDIT_INIT = 4
);
  localparam int CW = $clog2(CREDIT_INIT + 1);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        yummy_i;
  logic                      link_valid_o;
  logic [DATA_W-1:0]         link_data_o;
  logic [SW-1:0]             link_src_o;
  logic                      drain_i;
  logic                      drain_done_o;
  logic [NUM_REQ*CW-1:0]     credit_o;
  logic                      err_o;

  modport slave (
    input  req_valid_i, req_data_i, yummy_i, drain_i,
    output req_ready_o, link_valid_o, link_data_o, link_src_o,
           drain_done_o, credit_o, err_o
  );

  modport master (
    output req_valid_i, req_data_i, yummy_i, drain_i,
    input  req_ready_o, link_valid_o, link_data_o, link_src_o,
           drain_done_o, credit_o, err_o
  );
endinterface

// File: rtl/mpi_credit_arbiter.sv
// Round-robin, credit-based arbiter merging NUM_REQ requester channels onto a
// single outgoing MPI link. Each channel owns CREDIT_INIT credits; a grant
// spends one, a yummy from the remote receiver returns one.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_INIT  | one cycle after reset, no grants, yummies still counted
// ST_RUN   | normal arbitration among channels with flits and credits
// ST_DRAIN | grants stopped, waiting for every credit to come home
module mpi_credit_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int CREDIT_INIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mpi_credit_arbiter_if.slave   bus
);

  localparam int CW = $clog2(CREDIT_INIT + 1);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0]   CRED_FULL = CW'(CREDIT_INIT);
  localparam logic [SW:0]     NUM_REQ_W = (SW+1)'(NUM_REQ);
  localparam logic [SW-1:0]   LAST_INIT = SW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_credit [NUM_REQ];
  logic [SW-1:0]           r_last_grant;
  logic                    r_link_valid;
  logic [DATA_W-1:0]       r_link_data;
  logic [SW-1:0]           r_link_src;
  logic                    r_err;

  logic [NUM_REQ-1:0]      w_eligible;
  logic [NUM_REQ-1:0]      w_full;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_grant_any;
  logic [SW-1:0]           w_grant_idx;
  logic [SW:0]             w_sum;
  logic [SW-1:0]           w_cand;
  logic [NUM_REQ*CW-1:0]   w_credit_flat;

  // Per-channel eligibility and "all credits home" flags.
  always_comb begin
    w_eligible = '0;
    w_full     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_eligible[k] = (r_state == ST_RUN) && bus.req_valid_i[k] && (r_credit[k] != '0);
      w_full[k]     = (r_credit[k] == CRED_FULL);
    end
  end

  // Round-robin pick: scan from the channel after the last grant, wrapping once.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_last_grant} + (SW+1)'(1) + (SW+1)'(i);
      if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
      w_cand = w_sum[SW-1:0];
      if (!w_grant_any && w_eligible[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a grant in the cycle drain_i rises still completes
  // because w_grant is based on the current state, not the next one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  w_state_nxt = ST_RUN;
      ST_RUN:   if (bus.drain_i)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!bus.drain_i) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Round-robin pointer moves only when something is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            r_last_grant <= LAST_INIT;
    else if (w_grant_any) r_last_grant <= w_grant_idx;
  end

  // Credit counters: grant spends, yummy returns, both together cancel.
  // A yummy on a full counter without a grant is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) r_credit[k] <= CRED_FULL;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        case ({w_grant[k], bus.yummy_i[k]})
          2'b10:   r_credit[k] <= r_credit[k] - CW'(1);
          2'b01:   if (!w_full[k]) r_credit[k] <= r_credit[k] + CW'(1);
          default: r_credit[k] <= r_credit[k];
        endcase
      end
    end
  end

  // Sticky overflow flag for yummies that arrive with no credit outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        r_err <= 1'b0;
    else if (|(bus.yummy_i & w_full & ~w_grant))      r_err <= 1'b1;
  end

  // Link output stage: one-cycle registered copy of the granted flit;
  // payload and source hold when nothing is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_link_valid <= 1'b0;
      r_link_data  <= '0;
      r_link_src   <= '0;
    end else begin
      r_link_valid <= w_grant_any;
      if (w_grant_any) begin
        r_link_data <= bus.req_data_i[w_grant_idx*DATA_W +: DATA_W];
        r_link_src  <= w_grant_idx;
      end
    end
  end

  // Flatten the credit counters for observation.
  always_comb begin
    w_credit_flat = '0;
    for (int k = 0; k < NUM_REQ; k++) w_credit_flat[k*CW +: CW] = r_credit[k];
  end

  assign bus.req_ready_o  = w_grant;
  assign bus.link_valid_o = r_link_valid;
  assign bus.link_data_o  = r_link_data;
  assign bus.link_src_o   = r_link_src;
  assign bus.drain_done_o = (r_state == ST_DRAIN) && (&w_full);
  assign bus.credit_o     = w_credit_flat;
  assign bus.err_o        = r_err;

endmodule

// File: tb/tb_mpi_credit_arbiter.sv
// Directed bench for mpi_credit_arbiter (4 channels, 64-bit flits, 4 credits).
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after.
module tb_mpi_credit_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int CI = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mpi_credit_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .CREDIT_INIT(CI)) bus ();

  mpi_credit_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CREDIT_INIT(CI)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] payload(input int k);
    return {32'hDA7A_0000, 32'(k)};
  endfunction

  function automatic logic [63:0] cred(input int k);
    logic [NR*CW-1:0] flat;
    flat = bus.credit_o;
    return 64'(flat[k*CW +: CW]);
  endfunction

  task automatic drive_idle();
    bus.req_valid_i = '0;
    bus.yummy_i     = '0;
    bus.drain_i     = 1'b0;
    for (int k = 0; k < NR; k++) bus.req_data_i[k*DW +: DW] = payload(k);
  endtask

  // Leaves the bench 1 ns after the edge that moves INIT -> RUN.
  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;

    // ---- reset values and round-robin exhaustion of all credits ----
    step();
    step();
    #1;
    check_val("rst_link_valid", 64'(bus.link_valid_o), 64'd0);
    check_val("rst_link_data",  bus.link_data_o,       64'd0);
    check_val("rst_link_src",   64'(bus.link_src_o),   64'd0);
    check_val("rst_credits",    64'(bus.credit_o),     64'h924);
    check_val("rst_err",        64'(bus.err_o),        64'd0);
    check_val("rst_drain_done", 64'(bus.drain_done_o), 64'd0);
    check_val("rst_ready",      64'(bus.req_ready_o),  64'd0);
    rst = 1'b0;
    bus.req_valid_i = 4'hF;
    #1;
    check_val("init_no_grant", 64'(bus.req_ready_o), 64'd0);
    step();
    for (int i = 0; i < 16; i++) begin
      #1;
      check_val("rr_grant", 64'(bus.req_ready_o), 64'(1 << (i % 4)));
      if (i > 0) begin
        check_val("rr_link_valid", 64'(bus.link_valid_o), 64'd1);
        check_val("rr_link_src",   64'(bus.link_src_o),   64'((i - 1) % 4));
      end
      step();
    end
    #1;
    check_val("rr_last_valid", 64'(bus.link_valid_o), 64'd1);
    check_val("rr_last_src",   64'(bus.link_src_o),   64'd3);
    check_val("rr_last_data",  bus.link_data_o,       payload(3));
    check_val("rr_exhausted",  64'(bus.req_ready_o),  64'd0);
    check_val("rr_credits0",   64'(bus.credit_o),     64'd0);
    step();
    #1;
    check_val("rr_link_idle",  64'(bus.link_valid_o), 64'd0);
    check_val("rr_data_hold",  bus.link_data_o,       payload(3));

    // ---- single channel 2: spend, stall, one yummy, resume ----
    do_reset();
    bus.req_valid_i = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      bus.req_data_i[2*DW +: DW] = 64'h1234_0000_0000_0000 + 64'(j);
      #1;
      check_val("ch2_grant", 64'(bus.req_ready_o), 64'h4);
      step();
      #1;
      check_val("ch2_link_valid", 64'(bus.link_valid_o), 64'd1);
      check_val("ch2_link_data",  bus.link_data_o, 64'h1234_0000_0000_0000 + 64'(j));
      check_val("ch2_link_src",   64'(bus.link_src_o), 64'd2);
    end
    bus.req_data_i[2*DW +: DW] = 64'h1234_0000_0000_0004;
    check_val("ch2_stall",   64'(bus.req_ready_o), 64'd0);
    check_val("ch2_credit0", cred(2), 64'd0);
    step();
    #1;
    check_val("ch2_stall_link", 64'(bus.link_valid_o), 64'd0);
    bus.yummy_i = 4'b0100;
    #1;
    check_val("ch2_yummy_cycle", 64'(bus.req_ready_o), 64'd0);
    step();
    bus.yummy_i = '0;
    #1;
    check_val("ch2_credit1", cred(2), 64'd1);
    check_val("ch2_regrant", 64'(bus.req_ready_o), 64'h4);
    step();
    #1;
    check_val("ch2_fifth_data",  bus.link_data_o, 64'h1234_0000_0000_0004);
    check_val("ch2_fifth_valid", 64'(bus.link_valid_o), 64'd1);
    bus.req_valid_i = '0;

    // ---- grant and yummy in the same cycle on channel 1 ----
    do_reset();
    bus.req_valid_i = 4'b0010;
    step();
    step();
    step();
    #1;
    check_val("ch1_credit1", cred(1), 64'd1);
    bus.yummy_i = 4'b0010;
    #1;
    check_val("ch1_grant_w_yummy", 64'(bus.req_ready_o), 64'h2);
    step();
    bus.req_valid_i = '0;
    bus.yummy_i     = '0;
    #1;
    check_val("ch1_credit_same", cred(1), 64'd1);
    check_val("ch1_err_clear",   64'(bus.err_o), 64'd0);

    // ---- yummy overflow on channel 0 is sticky until reset ----
    do_reset();
    #1;
    check_val("ovf_err_before", 64'(bus.err_o), 64'd0);
    bus.yummy_i = 4'b0001;
    step();
    bus.yummy_i = '0;
    #1;
    check_val("ovf_credit_sat", cred(0), 64'd4);
    check_val("ovf_err_set",    64'(bus.err_o), 64'd1);
    step();
    step();
    step();
    #1;
    check_val("ovf_err_sticky", 64'(bus.err_o), 64'd1);
    do_reset();
    #1;
    check_val("ovf_err_reset", 64'(bus.err_o), 64'd0);

    // ---- drain: channels 0 and 3 spend two each, then wait for credits ----
    do_reset();
    bus.req_valid_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("drn_rr", 64'(bus.req_ready_o), (i % 2 == 0) ? 64'h1 : 64'h8);
      step();
    end
    bus.drain_i = 1'b1;
    #1;
    check_val("drn_grant_on_rise", 64'(bus.req_ready_o), 64'h8);
    step();
    #1;
    check_val("drn_no_grant",   64'(bus.req_ready_o),  64'd0);
    check_val("drn_last_valid", 64'(bus.link_valid_o), 64'd1);
    check_val("drn_last_src",   64'(bus.link_src_o),   64'd3);
    check_val("drn_done_early", 64'(bus.drain_done_o), 64'd0);
    check_val("drn_credit0",    cred(0), 64'd2);
    check_val("drn_credit3",    cred(3), 64'd2);
    bus.yummy_i = 4'b1001;
    step();
    #1;
    check_val("drn_done_half",  64'(bus.drain_done_o), 64'd0);
    step();
    bus.yummy_i = '0;
    #1;
    check_val("drn_done",       64'(bus.drain_done_o), 64'd1);
    check_val("drn_still_none", 64'(bus.req_ready_o),  64'd0);
    bus.drain_i = 1'b0;
    step();
    #1;
    check_val("drn_resume",     64'(bus.req_ready_o),  64'h1);
    check_val("drn_done_clear", 64'(bus.drain_done_o), 64'd0);
    bus.req_valid_i = '0;

    // ---- asynchronous reset in the middle of a burst ----
    do_reset();
    bus.req_valid_i = 4'hF;
    #1;
    check_val("ar_grant0", 64'(bus.req_ready_o), 64'h1);
    step();
    #1;
    check_val("ar_grant1", 64'(bus.req_ready_o), 64'h2);
    step();
    #1;
    check_val("ar_link_before", 64'(bus.link_valid_o), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("ar_link_cleared", 64'(bus.link_valid_o), 64'd0);
    check_val("ar_credits",      64'(bus.credit_o),     64'h924);
    check_val("ar_ready",        64'(bus.req_ready_o),  64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check_val("ar_init_no_grant", 64'(bus.req_ready_o), 64'd0);
    step();
    #1;
    check_val("ar_no_flit", 64'(bus.link_valid_o), 64'd0);
    check_val("ar_restart", 64'(bus.req_ready_o),  64'h1);
    bus.req_valid_i = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
